// File: rtl/data_mem_sized_pkg.sv
// Shared encodings for the sized data memory: access sizes, controller
// states and a helper that turns a size code into a byte count.
package dat_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int MAX_WAIT = 15;

  // Number of bytes touched by an access; the reserved code touches none.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/acknowledge bus between the CPU datapath and the sized data memory.
// The CPU side is the master; the memory is the slave.
interface data_mem_sized_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sgnExt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, size, sgnExt, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, size, sgnExt, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/data_mem_lane.sv
// Byte-lane steering for the sized data memory. Lane i of the packed
// vectors corresponds to memory byte (base address + i). Stores are turned
// into per-lane bytes according to endianness; loads are reassembled into a
// right-justified value and then sign- or zero-extended.
module data_mem_lane
  import dat_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  i_size,
  input  logic        i_sgnExt,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rbytes,
  output logic [31:0] o_wbytes,
  output logic [31:0] o_rdata
);

  logic [31:0] w_raw;

  // Reorder bytes between lane order and numeric order; little-endian is identity.
  always_comb begin
    o_wbytes = i_wdata;
    w_raw    = i_rbytes;
    if (BIG_ENDIAN) begin
      case (i_size)
        SZ_HALF: begin
          o_wbytes = {16'h0000, i_wdata[7:0], i_wdata[15:8]};
          w_raw    = {16'h0000, i_rbytes[7:0], i_rbytes[15:8]};
        end
        SZ_WORD: begin
          o_wbytes = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};
          w_raw    = {i_rbytes[7:0], i_rbytes[15:8], i_rbytes[23:16], i_rbytes[31:24]};
        end
        default: begin
          o_wbytes = i_wdata;
          w_raw    = i_rbytes;
        end
      endcase
    end
  end

  // Extend the assembled load value; a word load has nothing to extend.
  always_comb begin
    o_rdata = w_raw;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sgnExt & w_raw[7]}}, w_raw[7:0]};
      SZ_HALF: o_rdata = {{16{i_sgnExt & w_raw[15]}}, w_raw[15:0]};
      default: o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed data memory with byte/half/word accesses, configurable
// endianness and wait states, behind a req/ack handshake. Bad requests
// (reserved size, misalignment, running past the end) complete with err set
// and never touch the array.
module data_mem_sized
  import dat_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 32,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rstN,
  data_mem_sized_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  state_e            r_state;
  state_e            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sgnExt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [DEPTH_BYTES];

  logic              w_busy;
  logic              w_ack;
  logic              w_accept;
  logic              w_doAccess;
  logic              w_doWrite;
  logic              w_err;
  logic              w_rangeErr;
  logic [2:0]        w_nb;
  logic [ADDR_W:0]   w_end;
  logic [IDX_W-1:0]  w_base;
  logic [31:0]       w_rbytes;
  logic [31:0]       w_wbytes;
  logic [31:0]       w_ldata;

  // Controller state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; RESP can take a new request directly.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_ack  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) w_next = ACCESS;
      end
      ACCESS: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        w_ack  = 1'b1;
        w_next = bus.req ? ACCESS : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept   = !w_busy && bus.req;
  assign w_doAccess = (r_state == ACCESS) && (r_cnt == 4'd0);

  // The end address is one bit wider than the address so it cannot wrap.
  assign w_nb       = nbytes(r_size);
  assign w_end      = {1'b0, r_addr} + {{(ADDR_W-2){1'b0}}, w_nb};
  assign w_rangeErr = w_end > (ADDR_W+1)'(DEPTH_BYTES);
  assign w_err      = (r_size == SZ_RSVD)
                   || ((r_size == SZ_HALF) && r_addr[0])
                   || ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00))
                   || w_rangeErr;
  assign w_doWrite  = w_doAccess && r_we && !w_err;
  assign w_base     = r_addr[IDX_W-1:0];

  // Gather the four bytes starting at the base; only used when in range.
  always_comb begin
    w_rbytes = '0;
    for (int i = 0; i < 4; i++) begin
      w_rbytes[8*i +: 8] = r_mem[w_base + IDX_W'(i)];
    end
  end

  data_mem_lane #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .i_size   (r_size),
    .i_sgnExt (r_sgnExt),
    .i_wdata  (r_wdata),
    .i_rbytes (w_rbytes),
    .o_wbytes (w_wbytes),
    .o_rdata  (w_ldata)
  );

  // Capture the request, count wait states, then register the result.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_sgnExt <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= 4'(WAIT_CYCLES);
      r_we     <= bus.we;
      r_size   <= bus.size;
      r_sgnExt <= bus.sgnExt;
      r_addr   <= bus.addr;
      r_wdata  <= bus.wdata;
    end else if (r_state == ACCESS) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'h0 : w_ldata;
      end
    end
  end

  // Array write: all lanes of a store land on the same edge, or none do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_doWrite && (3'(i) < w_nb)) begin
        r_mem[w_base + IDX_W'(i)] <= w_wbytes[8*i +: 8];
      end
    end
  end

  assign bus.busy  = w_busy;
  assign bus.ack   = w_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: one big-endian zero-wait instance and one
// little-endian two-wait instance, driven with directed and random requests
// and compared every cycle against a byte-array model of the memory.
module tb_data_mem_sized;
  import dat_mem_pkg::*;

  localparam int DEPTH = 128;
  localparam int W0    = 0;
  localparam int W1    = 2;

  typedef struct {
    int          t0;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  int         cyc  = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mdl [2][DEPTH];

  data_mem_sized_if #(.ADDR_W(32)) bus0 ();
  data_mem_sized_if #(.ADDR_W(32)) bus1 ();

  data_mem_sized #(
    .DEPTH_BYTES(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b1), .WAIT_CYCLES(W0)
  ) dut0 (
    .clk(clk), .rstN(rstN), .bus(bus0)
  );

  data_mem_sized #(
    .DEPTH_BYTES(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b0), .WAIT_CYCLES(W1)
  ) dut1 (
    .clk(clk), .rstN(rstN), .bus(bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waitOf(int k);
    return (k == 0) ? W0 : W1;
  endfunction

  // A request accepted at edge t0 keeps the memory busy through edge t0+W.
  function automatic bit modelBusy(int k, int n);
    if (k == 0) begin
      foreach (q0[i]) if (n >= q0[i].t0 && n <= q0[i].t0 + W0) return 1'b1;
    end else begin
      foreach (q1[i]) if (n >= q1[i].t0 && n <= q1[i].t0 + W1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic getAck(int k);
    return (k == 0) ? bus0.ack : bus1.ack;
  endfunction

  function automatic logic [31:0] getRdata(int k);
    return (k == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  function automatic logic getErr(int k);
    return (k == 0) ? bus0.err : bus1.err;
  endfunction

  task automatic checkVal(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(int k, logic r, logic w, logic [1:0] sz, logic s,
                       logic [31:0] a, logic [31:0] d);
    if (k == 0) begin
      bus0.req = r; bus0.we = w; bus0.size = sz; bus0.sgnExt = s;
      bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.size = sz; bus1.sgnExt = s;
      bus1.addr = a; bus1.wdata = d;
    end
  endtask

  // Reference behaviour: byte counts, error rules and byte ordering in plain arithmetic.
  task automatic modelAccess(input int k, input logic w, input logic [1:0] sz,
                             input logic s, input logic [31:0] a, input logic [31:0] d,
                             input bit apply, output logic [31:0] rd, output logic er);
    int     nb;
    int     ai;
    longint v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
      || (({32'h0, a} + 64'(nb)) > 64'(DEPTH));
    rd = 32'h0;
    if (!er) begin
      ai = int'(a);
      if (w) begin
        if (apply) begin
          for (int i = 0; i < nb; i++) begin
            if (k == 0) mdl[k][ai + nb - 1 - i] = 8'((d >> (8 * i)) & 32'hFF);
            else        mdl[k][ai + i]          = 8'((d >> (8 * i)) & 32'hFF);
          end
        end
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) begin
          if (k == 0) v = v * 256 + longint'(mdl[k][ai + i]);
          else        v = v + (longint'(mdl[k][ai + i]) << (8 * i));
        end
        if (nb < 4 && s && v >= (longint'(1) << (8 * nb - 1)))
          v = v - (longint'(1) << (8 * nb));
        rd = 32'(v);
      end
    end
  endtask

  // Present a request and hold it until the model says the memory accepts it.
  task automatic issue(input int k, input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input bit apply,
                       output int t0);
    exp_t        e;
    int          guard;
    logic [31:0] rdE;
    logic        erE;
    @(negedge clk);
    drive(k, 1'b1, w, sz, s, a, d);
    guard = 0;
    while (modelBusy(k, cyc) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout dut%0d: got busy, expected idle", k);
    end
    t0 = cyc + 1;
    modelAccess(k, w, sz, s, a, d, apply, rdE, erE);
    e.t0 = t0;
    e.rd = rdE;
    e.er = erE;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle(int k);
    @(negedge clk);
    drive(k, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  // Issue one request, drop req, and capture the DUT response and its latency.
  task automatic issueWait(input int k, input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat);
    int t0;
    int guard;
    issue(k, w, sz, s, a, d, 1'b1, t0);
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    guard = 0;
    while (!getAck(k) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack timeout dut%0d: got no ack, expected ack", k);
    end
    rd  = getRdata(k);
    er  = getErr(k);
    lat = cyc - t0;
  endtask

  task automatic cmpOne(int k, logic ack, logic busy, logic [31:0] rd, logic er);
    exp_t e;
    bit   expAck;
    int   w;
    w      = waitOf(k);
    expAck = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].t0 + w + 1 == cyc) begin
        expAck = 1'b1;
        e = q0.pop_front();
      end
    end else begin
      if (q1.size() > 0 && q1[0].t0 + w + 1 == cyc) begin
        expAck = 1'b1;
        e = q1.pop_front();
      end
    end
    checkVal($sformatf("ack dut%0d cyc%0d", k, cyc), {31'h0, ack}, {31'h0, expAck});
    checkVal($sformatf("busy dut%0d cyc%0d", k, cyc), {31'h0, busy}, {31'h0, modelBusy(k, cyc)});
    if (expAck) begin
      checkVal($sformatf("rdata dut%0d cyc%0d", k, cyc), rd, e.rd);
      checkVal($sformatf("err dut%0d cyc%0d", k, cyc), {31'h0, er}, {31'h0, e.er});
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rstN) begin
      cmpOne(0, bus0.ack, bus0.busy, bus0.rdata, bus0.err);
      cmpOne(1, bus1.ack, bus1.busy, bus1.rdata, bus1.err);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          t0a, t0b, t0c;
    logic [31:0] word;
    logic [1:0]  sz;
    logic [31:0] a;

    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkVal("reset ack0",   {31'h0, bus0.ack},  32'h0);
    checkVal("reset err0",   {31'h0, bus0.err},  32'h0);
    checkVal("reset busy0",  {31'h0, bus0.busy}, 32'h0);
    checkVal("reset rdata0", bus0.rdata,         32'h0);
    checkVal("reset rdata1", bus1.rdata,         32'h0);
    #2 rstN = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i += 4) issue(k, 1'b1, SZ_WORD, 1'b0, 32'(i), $urandom, 1'b1, t0a);
      idle(k);
    end

    // Big-endian, zero-wait instance.
    word = 32'h11223344;
    issueWait(0, 1'b1, SZ_WORD, 1'b0, 32'd8, word, rd, er, lat);
    checkVal("be store err", {31'h0, er}, 32'h0);
    checkVal("be store lat", 32'(lat), 32'd1);
    for (int i = 0; i < 4; i++) begin
      issueWait(0, 1'b0, SZ_BYTE, 1'b0, 32'(8 + i), 32'h0, rd, er, lat);
      checkVal($sformatf("be byte %0d", 8 + i), rd, {24'h0, word[31 - 8*i -: 8]});
      checkVal("be load lat", 32'(lat), 32'd1);
    end
    issueWait(0, 1'b0, SZ_WORD, 1'b1, 32'd8, 32'h0, rd, er, lat);
    checkVal("be word load", rd, 32'h11223344);
    checkVal("be word err", {31'h0, er}, 32'h0);

    issueWait(0, 1'b1, SZ_BYTE, 1'b0, 32'd5, 32'h00000080, rd, er, lat);
    issueWait(0, 1'b0, SZ_BYTE, 1'b1, 32'd5, 32'h0, rd, er, lat);
    checkVal("byte sext", rd, 32'hFFFFFF80);
    issueWait(0, 1'b0, SZ_BYTE, 1'b0, 32'd5, 32'h0, rd, er, lat);
    checkVal("byte zext", rd, 32'h00000080);
    issueWait(0, 1'b1, SZ_HALF, 1'b0, 32'd6, 32'h00008001, rd, er, lat);
    issueWait(0, 1'b0, SZ_HALF, 1'b1, 32'd6, 32'h0, rd, er, lat);
    checkVal("half sext", rd, 32'hFFFF8001);

    issueWait(0, 1'b0, SZ_HALF, 1'b0, 32'd3, 32'h0, rd, er, lat);
    checkVal("misaligned err", {31'h0, er}, 32'h1);
    checkVal("misaligned rdata", rd, 32'h0);
    issueWait(0, 1'b1, SZ_HALF, 1'b0, 32'd126, 32'h00005A5A, rd, er, lat);
    issueWait(0, 1'b1, SZ_WORD, 1'b0, 32'd126, 32'hDEADBEEF, rd, er, lat);
    checkVal("range err", {31'h0, er}, 32'h1);
    issueWait(0, 1'b0, SZ_HALF, 1'b0, 32'd126, 32'h0, rd, er, lat);
    checkVal("range untouched", rd, 32'h00005A5A);
    issueWait(0, 1'b0, SZ_RSVD, 1'b0, 32'd0, 32'h0, rd, er, lat);
    checkVal("rsvd err", {31'h0, er}, 32'h1);

    issue(0, 1'b1, SZ_WORD, 1'b0, 32'd20, 32'hA5A5_0F0F, 1'b1, t0a);
    issue(0, 1'b0, SZ_WORD, 1'b0, 32'd20, 32'h0, 1'b1, t0b);
    idle(0);
    checkVal("b2b spacing w0", 32'(t0b - t0a), 32'd2);

    // Little-endian, two-wait instance.
    issueWait(1, 1'b1, SZ_WORD, 1'b0, 32'd0, 32'h11223344, rd, er, lat);
    checkVal("le store lat", 32'(lat), 32'd3);
    issueWait(1, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'h0, rd, er, lat);
    checkVal("le byte 0", rd, 32'h00000044);
    checkVal("le load lat", 32'(lat), 32'd3);
    issue(1, 1'b0, SZ_HALF, 1'b0, 32'd2, 32'h0, 1'b1, t0a);
    issue(1, 1'b0, SZ_BYTE, 1'b1, 32'd1, 32'h0, 1'b1, t0b);
    issue(1, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0, 1'b1, t0c);
    idle(1);
    checkVal("b2b spacing w2", 32'(t0c - t0b), 32'd4);
    repeat (6) @(negedge clk);

    // Reset in the middle of a store: it must be dropped.
    issue(1, 1'b1, SZ_WORD, 1'b0, 32'd16, 32'hCAFEF00D, 1'b0, t0a);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1 rstN = 1'b0;
    q1.delete();
    #1;
    checkVal("async reset ack",   {31'h0, bus1.ack},  32'h0);
    checkVal("async reset busy",  {31'h0, bus1.busy}, 32'h0);
    checkVal("async reset rdata", bus1.rdata,         32'h0);
    @(negedge clk);
    #2 rstN = 1'b1;
    issueWait(1, 1'b0, SZ_WORD, 1'b0, 32'd16, 32'h0, rd, er, lat);

    // Random traffic with random gaps and back-to-back runs.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(0, 3) == 0) idle(k);
        case ($urandom_range(0, 9))
          0, 1, 2: sz = SZ_BYTE;
          3, 4, 5: sz = SZ_HALF;
          6, 7, 8: sz = SZ_WORD;
          default: sz = SZ_RSVD;
        endcase
        a = 32'($urandom_range(0, DEPTH + 7));
        if ($urandom_range(0, 2) != 0) a = a & ~((sz == SZ_WORD) ? 32'd3 : (sz == SZ_HALF) ? 32'd1 : 32'd0);
        issue(k, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1, t0a);
      end
      idle(k);
    end

    begin
      int guard;
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain: got %0d pending, expected 0", q0.size() + q1.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised byte-addressed data memory for the multicycle CPU, successor to the fixed 128-byte word-only data memory.
- Adds byte/half/word access sizes, sign/zero extension, selectable endianness and configurable wait states.
- Uses a req/ack handshake with alignment and range error reporting.
- Sits between the ALU-result/regB datapath and the write-back mux; the control FSM waits on ack.

Parameters:
- DEPTH_BYTES, 128, memory size in bytes; power of two, >= 4.
- ADDR_W, 32, address port width.
- BIG_ENDIAN, 1, 1 = lowest address holds the most significant byte; 0 = little-endian.
- WAIT_CYCLES, 0, extra cycles between accept and access, range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- req  in  1  access request, sampled when busy=0.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- sgnExt  in  1  load only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load result, extended; valid while ack=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack: misaligned, out of range, or reserved size.
- busy  out  1  request cannot be accepted this cycle.

Behaviour:
- Reset (rstN low, asynchronous) forces:
  - state IDLE, ack=0, err=0, rdata=0, wait counter=0.
  - Memory array is not cleared.
  - An in-flight store is dropped; memory stays unmodified.
- States and outputs:
  - IDLE: busy=0, ack=0.
  - ACCESS: busy=1, ack=0.
  - RESP: busy=0, ack=1.
- Acceptance:
  - When busy=0 and req=1 at a rising edge, capture addr, size, we, sgnExt and wdata.
  - Load cnt=WAIT_CYCLES and go to ACCESS.
  - Inputs are don't-care afterwards.
- In ACCESS, at each edge:
  - If cnt≠0: cnt--.
  - Else: perform the access, register rdata/err, go to RESP.
- RESP lasts exactly one cycle:
  - If req=1 at its closing edge, the new request is accepted (back-to-back) and the state goes to ACCESS.
  - Otherwise the state goes to IDLE.
- Latency: a request accepted at edge t0 has ack high from edge t0+WAIT_CYCLES+1 for one cycle. Throughput is one access per WAIT_CYCLES+2 cycles.
- Error checks, evaluated on the captured request:
  - Reserved size.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
  - addr+nbytes > DEPTH_BYTES, computed at ADDR_W+1 bits so it cannot wrap.
- On error:
  - err=1 and rdata=0.
  - No memory write occurs; no partial write ever.
- Store (no error):
  - nbytes = 1/2/4 low bytes of wdata written in one edge.
  - BIG_ENDIAN=1: mem[a] gets the most significant stored byte.
  - BIG_ENDIAN=0: mem[a] gets wdata[7:0].
  - rdata=0 on store ack.
- Load (no error):
  - Bytes are assembled per endianness into the low nbytes of rdata.
  - Upper bits come from sgnExt: sign bit replicated, or 0.
  - Word ignores sgnExt.
- Read-after-write: a load accepted in the RESP cycle of a store sees the new data.
- The memory is a single-port array, one clock edge, no negedge logic.

Decomposition:
- Package dat_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - state encoding IDLE/ACCESS/RESP.
  - function nbytes(size).
- Sub-module data_mem_lane (combinational) handles byte-lane steering:
  - Packs store bytes per endianness.
  - Unpacks load bytes and applies extension.
- The top level holds the FSM, counter, error check and array.

Test Plan:
- Word store then word load, BIG_ENDIAN=1, WAIT_CYCLES=0:
  - Store 0x11223344 at addr 8.
  - Byte loads at 8..11 return 0x11, 0x22, 0x33, 0x44.
  - Word load returns 0x11223344, err=0.
  - ack exactly one cycle, each 1 cycle after accept.
- Extension:
  - Store byte 0x80 at addr 5.
  - Byte load sgnExt=1 -> 0xFFFFFF80; sgnExt=0 -> 0x00000080.
  - Half store 0x8001 at 6, half load sgnExt=1 -> 0xFFFF8001.
- Errors:
  - Half load at addr 3 -> ack with err=1, rdata=0.
  - Word store 0xDEADBEEF at addr 126 (DEPTH 128) -> err=1, bytes 126/127 unchanged.
  - size=11 -> err=1.
- Latency and back-to-back:
  - WAIT_CYCLES=2, accept at edge 0 -> ack during cycle after edge 3.
  - busy=1 for edges 1..3; req held through RESP is accepted back-to-back.
- Reset and endianness:
  - Assert rstN=0 during ACCESS of a store -> ack=0, rdata=0 immediately, memory unchanged.
  - With BIG_ENDIAN=0, a word store of 0x11223344 at 0 then a byte load at 0 returns 0x44.
